fmadd_pn_normalizer: RTL
========================

Name: fmadd_pn_normalizer

Overview:
- Consumer side of the FMADD leading-zero detector.
- Takes the 24-bit pre-normalized mantissa, its signed working exponent and the 5-bit leading-zero count produced by FMADD_PN_LZD.
- Left-shifts the mantissa so the MSB is set, adjusts the exponent, and clamps to the denormal/zero cases.
- Two-stage elastic valid/ready pipeline between the FMA adder and the rounding stage.

Parameters:
- MAN_W, 24, mantissa width; must match the LZD input width.
- EXP_W, 7, signed two's-complement working exponent width (half-precision biased exponent plus guard bits).
- LZC_W, 5, leading-zero-count width; legal count range is 0..MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_l  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_man  in  MAN_W  unnormalized mantissa.
- in_exp  in  EXP_W  signed working exponent of in_man.
- in_lzc  in  LZC_W  leading-zero count of in_man from FMADD_PN_LZD.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- out_man  out  MAN_W  normalized mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_denorm  out  1  result clamped to the denormal range.
- out_zero  out  1  mantissa was all zero.

Behaviour:
- Reset: every output register (out_valid, out_man, out_exp, out_denorm, out_zero) and every internal valid and data register clears to 0 on the clk edge with rst_l=0. Reset mid-flight drops all in-flight beats. in_ready is 1 in the first cycle after reset.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 2 cycles from accept to out_valid.
  - Throughput is 1 beat per cycle.
  - Order is preserved; no beat is dropped or duplicated.
- Shift-amount computation (stage 1 input, combinational):
  - zero = (in_lzc >= MAN_W). This is the authoritative zero test; in_man is not re-checked.
  - If zero: sh=0, exp=0, denorm=0.
  - Else if in_exp <= 0 (signed): sh=0, exp=0, denorm=1.
  - Else if in_lzc >= in_exp: sh=in_exp-1, exp=0, denorm=1.
  - Else: sh=in_lzc, exp=in_exp-in_lzc, denorm=0.
- Stage 1 register: coarse shift by sh[4:3]×8 (0/8/16/24; 24 yields 0); holds sh[2:0], exp, denorm, zero.
- Stage 2 register: fine shift by sh[2:0]; drives out_* directly.
- Pipeline control:
  - Each stage loads when it is empty or its contents are leaving this cycle: s2_load = !s2_valid | out_ready; s1_load = !s1_valid | s2_load.
  - in_ready = s1_load.
- Stall behaviour: while out_valid & !out_ready, out_* hold stable; at most 2 beats are buffered; in_ready drops once both stages are full.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- Zero result: out_man=0, out_exp=0, out_zero=1, out_denorm=0.

Optional Feature:
- Macro FMADD_NORM_SKID_EN.
- Defined: a one-entry skid buffer is added at the input and in_ready becomes a pure register output, with no combinational path from out_ready. Accepted capacity rises to 3 beats. Latency is still 2 cycles when the skid buffer is empty, 3 when it is occupied. The skid buffer clears on reset.
- Undefined: in_ready is combinational from out_ready as described above.

Decomposition:
- Shared package fmadd_pkg holds:
  - constants MAN_W=24, EXP_W=7, LZC_W=5;
  - typedef norm_stage_t {man, exp, sh_fine, denorm, zero}.
- One natural sub-module: fmadd_norm_stage, a generic valid/ready register slice, instantiated twice (three times with FMADD_NORM_SKID_EN).

Test Plan:
- Normal case: in_man=24'h040000, in_exp=20, in_lzc=5 -> after 2 cycles out_man=24'h800000, out_exp=15, out_denorm=0, out_zero=0.
- Denormal clamp: in_man=24'h000100, in_exp=4, in_lzc=15 -> out_man=24'h000800, out_exp=0, out_denorm=1.
- Zero and non-positive exponent:
  - in_man=0, in_lzc=24, in_exp=9 -> out_man=0, out_exp=0, out_zero=1.
  - in_exp=-3, in_lzc=2 -> shift 0, out_denorm=1.
- Backpressure: stream beats A, B, C back-to-back with out_ready=0 for 4 cycles -> in_ready low while C is pending; A, B, C emerge in order once out_ready=1; out_* stable while stalled.
- Full throughput: 16 consecutive beats with out_ready=1 -> 16 results on 16 consecutive cycles, first result 2 cycles after the first accept.
- Reset mid-operation: assert rst_l=0 with 2 beats in flight -> out_valid=0 the next cycle, no stale beat appears after rst_l returns to 1, and in_ready=1.

Source files
------------

// File: rtl/fmadd_pkg.sv
// rtl/fmadd_pkg.sv - shared widths and stage payload type for the FMADD post-LZD normalizer
package fmadd_pkg;

    localparam int MAN_W = 24;
    localparam int EXP_W = 7;
    localparam int LZC_W = 5;
    localparam int SH_W  = 5;

    typedef struct packed {
        logic [MAN_W-1:0]        man;
        logic signed [EXP_W-1:0] exp;
        logic [2:0]              sh_fine;
        logic                    denorm;
        logic                    zero;
    } norm_stage_t;

endpackage

// File: rtl/fmadd_pn_normalizer_if.sv
// rtl/fmadd_pn_normalizer_if.sv - input and result handshake bundle of the normalizer
interface fmadd_pn_normalizer_if;
    import fmadd_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [MAN_W-1:0]        in_man;
    logic signed [EXP_W-1:0] in_exp;
    logic [LZC_W-1:0]        in_lzc;

    logic                    out_valid;
    logic                    out_ready;
    logic [MAN_W-1:0]        out_man;
    logic signed [EXP_W-1:0] out_exp;
    logic                    out_denorm;
    logic                    out_zero;

    modport master (
        output in_valid, in_man, in_exp, in_lzc, out_ready,
        input  in_ready, out_valid, out_man, out_exp, out_denorm, out_zero
    );

    modport slave (
        input  in_valid, in_man, in_exp, in_lzc, out_ready,
        output in_ready, out_valid, out_man, out_exp, out_denorm, out_zero
    );

endinterface

// File: rtl/fmadd_norm_stage.sv
// rtl/fmadd_norm_stage.sv - generic valid/ready register slice (pipeline or skid flavour)
module fmadd_norm_stage #(
    parameter int W    = 1,
    parameter bit SKID = 1'b0
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    generate
        if (SKID) begin : g_skid
            // Bypass when empty; park one beat when downstream refuses it.
            logic         full;
            logic [W-1:0] buf_data;

            assign in_ready  = !full;
            assign out_valid = full | in_valid;
            assign out_data  = full ? buf_data : in_data;

            always_ff @(posedge clk) begin
                if (!rst_l) begin
                    full     <= 1'b0;
                    buf_data <= '0;
                end else if (full) begin
                    if (out_ready) begin
                        full <= 1'b0;
                    end
                end else if (in_valid && !out_ready) begin
                    full     <= 1'b1;
                    buf_data <= in_data;
                end
            end
        end else begin : g_pipe
            logic         valid;
            logic [W-1:0] data;
            logic         load;

            assign load      = !valid | out_ready;
            assign in_ready  = load;
            assign out_valid = valid;
            assign out_data  = data;

            always_ff @(posedge clk) begin
                if (!rst_l) begin
                    valid <= 1'b0;
                    data  <= '0;
                end else if (load) begin
                    valid <= in_valid;
                    if (in_valid) begin
                        data <= in_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fmadd_pn_normalizer.sv
// rtl/fmadd_pn_normalizer.sv - two-stage mantissa normalizer after the LZD; FMADD_NORM_SKID_EN adds an input skid buffer
module fmadd_pn_normalizer
    import fmadd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_l,
    fmadd_pn_normalizer_if.slave  bus
);

    localparam int RAW_W = MAN_W + EXP_W + LZC_W;
    localparam int S1_W  = $bits(norm_stage_t);
    localparam int S2_W  = MAN_W + EXP_W + 2;

    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [LZC_W-1:0]        LZC_MAX  = LZC_W'(MAN_W);

    logic                    f_valid;
    logic                    f_ready;
    logic [RAW_W-1:0]        f_data;
    logic [MAN_W-1:0]        f_man;
    logic signed [EXP_W-1:0] f_exp;
    logic [LZC_W-1:0]        f_lzc;

`ifdef FMADD_NORM_SKID_EN
    fmadd_norm_stage #(
        .W    (RAW_W),
        .SKID (1'b1)
    ) u_skid (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.in_man, bus.in_exp, bus.in_lzc}),
        .out_valid (f_valid),
        .out_ready (f_ready),
        .out_data  (f_data)
    );
`else
    assign f_valid      = bus.in_valid;
    assign bus.in_ready = f_ready;
    assign f_data       = {bus.in_man, bus.in_exp, bus.in_lzc};
`endif

    assign {f_man, f_exp, f_lzc} = f_data;

    logic signed [EXP_W-1:0] lzc_ext;
    logic [SH_W-1:0]         sh;
    norm_stage_t             s1_in;

    assign lzc_ext = EXP_W'(f_lzc);

    // The LZD count is trusted for zero detection; the mantissa is not re-scanned.
    always_comb begin
        s1_in = '0;
        sh    = '0;
        if (f_lzc >= LZC_MAX) begin
            s1_in.zero = 1'b1;
        end else if (f_exp <= EXP_ZERO) begin
            s1_in.man    = f_man;
            s1_in.denorm = 1'b1;
        end else if (lzc_ext >= f_exp) begin
            sh           = SH_W'(f_exp - EXP_ONE);
            s1_in.man    = f_man << {sh[4:3], 3'b000};
            s1_in.denorm = 1'b1;
        end else begin
            sh        = f_lzc;
            s1_in.man = f_man << {sh[4:3], 3'b000};
            s1_in.exp = f_exp - lzc_ext;
        end
        s1_in.sh_fine = sh[2:0];
    end

    logic              s1_valid;
    logic              s1_ready;
    logic [S1_W-1:0]   s1_raw;
    norm_stage_t       s1_out;
    logic [S2_W-1:0]   s2_in;
    logic [S2_W-1:0]   s2_out;
    logic [MAN_W-1:0]  fine_man;

    fmadd_norm_stage #(
        .W    (S1_W),
        .SKID (1'b0)
    ) u_s1 (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (f_valid),
        .in_ready  (f_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_raw)
    );

    assign s1_out   = norm_stage_t'(s1_raw);
    assign fine_man = s1_out.man << s1_out.sh_fine;
    assign s2_in    = {fine_man, s1_out.exp, s1_out.denorm, s1_out.zero};

    fmadd_norm_stage #(
        .W    (S2_W),
        .SKID (1'b0)
    ) u_s2 (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_out)
    );

    assign {bus.out_man, bus.out_exp, bus.out_denorm, bus.out_zero} = s2_out;

endmodule
